ext_obi_addr_router: RTL
========================

// Module: ext_obi_addr_router
// PURPOSE
//  Parametrised 1-to-NSLAVE OBI router for the external-slave crossbar of keccak_x_heep.
//  - Decodes each request address against a table of [start,end) rules.
//  - Forwards the request to the matching slave and routes the responses back in order.
//  - Completes unmapped accesses with an internal error responder instead of hanging the bus.
//  - Replaces the fixed single-slave address map, so further accelerators can be added by parameter only.
// PARAMETERS
//  NSLAVE      1            number of downstream slave ports (>=1)
//  ADDR_W      32           address width
//  DATA_W      32           data width; BE width = DATA_W/8
//  MAX_OUTST   4            max in-flight transactions (>=1); counter width $clog2(MAX_OUTST+1)
//  ADDR_RULES  '{default:0} addr_map_rule_t [NSLAVE-1:0] decode table (idx, start_addr, end_addr)
//  ERR_RDATA   32'hBADACCE5 rdata returned for unmapped accesses
// PORTS
//  clk_i        in   1               clock
//  rst_i        in   1               asynchronous reset, active-high
//  m_req_i      in   1               master request
//  m_gnt_o      out  1               master grant
//  m_addr_i     in   ADDR_W          master address
//  m_we_i       in   1               write enable
//  m_be_i       in   DATA_W/8        byte enables
//  m_wdata_i    in   DATA_W          write data
//  m_rvalid_o   out  1               response valid to master
//  m_rdata_o    out  DATA_W          response data to master
//  m_err_o      out  1               response is a decode error (qualified by m_rvalid_o)
//  s_req_o      out  NSLAVE          per-slave request
//  s_gnt_i      in   NSLAVE          per-slave grant
//  s_addr_o/s_we_o/s_be_o/s_wdata_o  out  broadcast copies of the m_* fields
//  s_rvalid_i   in   NSLAVE          per-slave response valid
//  s_rdata_i    in   NSLAVE*DATA_W   per-slave response data, packed; slave k at [k*DATA_W +: DATA_W]
//  err_cnt_o    out  16              saturating count of decode errors
// BEHAVIOUR
//  Decode (combinational):
//  - sel = lowest k with start_addr[k] <= addr < end_addr[k] (end exclusive; lowest index wins on overlap).
//  - No hit -> sel = NSLAVE (error target).
//  State:
//  - out_cnt: in-flight transaction count.
//  - cur_sel: target of the in-flight transactions.
//  - err_pend: error responder has a response queued.
//  - err_cnt_o: decode-error counter.
//  - Reset values: out_cnt=0, cur_sel=0, err_pend=0, err_cnt_o=0.
//  - Output reset values: m_gnt_o=0, m_rvalid_o=0, m_err_o=0, m_rdata_o=0, s_req_o=0.
//  Accept condition (ordering rule):
//  - allow = (out_cnt==0) | (sel==cur_sel & out_cnt<MAX_OUTST).
//  - Switching target while transactions are outstanding stalls: no s_req_o and m_gnt_o=0 until out_cnt==0.
//  Forward path:
//  - s_req_o[sel] = m_req_i & allow (zero-latency, combinational).
//  - m_gnt_o = s_gnt_i[sel] & allow, or for the error target m_gnt_o = m_req_i & allow.
//  - Handshake hs = m_req_i & m_gnt_o.
//  - On hs: cur_sel <= sel. If sel==NSLAVE, err_pend <= 1.
//  Error responder:
//  - Returns m_rvalid_o=1, m_rdata_o=ERR_RDATA, m_err_o=1 exactly 1 cycle after its handshake.
//  - Writes to unmapped space are dropped.
//  - err_cnt_o increments on each error handshake and saturates at 16'hFFFF.
//  Response path:
//  - m_rvalid_o = s_rvalid_i[cur_sel] (or err_pend when cur_sel==NSLAVE); rdata muxed the same way; m_err_o=0 for real slaves.
//  - s_rvalid_i from a non-current slave is ignored.
//  Counter update:
//  - out_cnt +1 on hs, -1 on a routed rvalid; both in the same cycle -> unchanged.
//  - Never exceeds MAX_OUTST and never underflows; a stray rvalid at out_cnt==0 is ignored.
//  Reset mid-operation:
//  - All state clears asynchronously.
//  - Responses to pre-reset transactions arriving after reset are dropped (out_cnt==0).
// STRUCTURE
//  Shared package ext_xbar_pkg (extends the keccak_x_heep address map):
//  - EXT_XBAR_NSLAVE.
//  - Per-slave START/SIZE/END/IDX constants.
//  - EXT_XBAR_ADDR_RULES.
//  - ERR_RDATA.
//  - Reuses addr_map_rule_t from addr_map_rule_pkg.
//  Sub-module ext_obi_err_slave: 1-cycle error responder with the saturating counter.
//  Decode and routing stay in the top module.
// TESTING
//  1. NSLAVE=2, rules [0x0,0x1000),[0x1000,0x2000):
//     - read 0x1004 -> s_req_o=2'b10; slave1 rdata 0xCAFE returned on m_rdata_o, m_err_o=0.
//  2. Read 0x3000 (unmapped):
//     - m_gnt_o same cycle; next cycle m_rvalid_o=1, m_rdata_o=0xBADACCE5, m_err_o=1; err_cnt_o=1.
//  3. MAX_OUTST=4, slave0 grants always and delays rvalid:
//     - 4 back-to-back reads granted; 5th sees m_gnt_o=0 until the first rvalid.
//  4. Two reads to slave0 outstanding, then a request to slave1:
//     - s_req_o[1]=0 until both slave0 responses are returned, then granted.
//  5. Handshake and rvalid in the same cycle at out_cnt=2 -> out_cnt stays 2.
//  6. Reset asserted with 3 transactions outstanding:
//     - all outputs 0 next edge; a late s_rvalid_i does not raise m_rvalid_o.

Source files
------------

// File: rtl/addr_map_rule_pkg.sv
`default_nettype none
// =====================================================================
// Package : addr_map_rule_pkg
// Brief   : Address-map rule record shared by the bus crossbars.
// Rev     : 1.0
// =====================================================================
package addr_map_rule_pkg;

   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] start_addr;
      logic [31:0] end_addr;
   } addr_map_rule_t;

endpackage
`default_nettype wire

// File: rtl/ext_xbar_pkg.sv
`default_nettype none
// =====================================================================
// Package : ext_xbar_pkg
// Brief   : External-slave address map; a new accelerator is one more rule.
// Rev     : 1.0
// =====================================================================
package ext_xbar_pkg;
   import addr_map_rule_pkg::*;

   localparam int unsigned EXT_XBAR_NSLAVE = 2;

   localparam logic [31:0] EXT_SLV0_START_ADDR = 32'h0000_0000;
   localparam logic [31:0] EXT_SLV0_SIZE       = 32'h0000_1000;
   localparam logic [31:0] EXT_SLV0_END_ADDR   = EXT_SLV0_START_ADDR + EXT_SLV0_SIZE;
   localparam logic [31:0] EXT_SLV0_IDX        = 32'd0;

   localparam logic [31:0] EXT_SLV1_START_ADDR = 32'h0000_1000;
   localparam logic [31:0] EXT_SLV1_SIZE       = 32'h0000_1000;
   localparam logic [31:0] EXT_SLV1_END_ADDR   = EXT_SLV1_START_ADDR + EXT_SLV1_SIZE;
   localparam logic [31:0] EXT_SLV1_IDX        = 32'd1;

   localparam addr_map_rule_t [EXT_XBAR_NSLAVE-1:0] EXT_XBAR_ADDR_RULES = '{
      1: '{idx: EXT_SLV1_IDX, start_addr: EXT_SLV1_START_ADDR, end_addr: EXT_SLV1_END_ADDR},
      0: '{idx: EXT_SLV0_IDX, start_addr: EXT_SLV0_START_ADDR, end_addr: EXT_SLV0_END_ADDR}
   };

   localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

endpackage
`default_nettype wire

// File: rtl/ext_obi_addr_router_if.sv
`default_nettype none
// =====================================================================
// Interface : ext_obi_addr_router_if
// Brief     : OBI bundle with N_PORT request/response lanes sharing one A-channel.
// Rev       : 1.0
// =====================================================================
interface ext_obi_addr_router_if #(
   parameter int N_PORT = 1,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [N_PORT-1:0]        req;
   logic [N_PORT-1:0]        gnt;
   logic [ADDR_W-1:0]        addr;
   logic                     we;
   logic [DATA_W/8-1:0]      be;
   logic [DATA_W-1:0]        wdata;
   logic [N_PORT-1:0]        rvalid;
   logic [N_PORT*DATA_W-1:0] rdata;
   logic                     err;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface
`default_nettype wire

// File: rtl/ext_obi_err_slave.sv
`default_nettype none
// =====================================================================
// Module : ext_obi_err_slave
// Brief  : Answers unmapped accesses one cycle after grant; counts them.
// Rev    : 1.0
// =====================================================================
module ext_obi_err_slave #(
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] ERR_RDATA = '0
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              i_hs,
   output logic                   o_rvalid,
   output logic [DATA_W-1:0]      o_rdata,
   output logic                   o_err,
   output logic [15:0]            o_err_cnt
);
   logic        r_pend;
   logic [15:0] r_err_cnt;

   // Write data is never stored; every access just gets an error response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend    <= 1'b0;
         r_err_cnt <= 16'h0000;
      end else begin
         r_pend <= i_hs;
         if (i_hs && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
      end
   end

   assign o_rvalid  = r_pend;
   assign o_rdata   = r_pend ? ERR_RDATA : '0;
   assign o_err     = r_pend;
   assign o_err_cnt = r_err_cnt;
endmodule
`default_nettype wire

// File: rtl/ext_obi_addr_router.sv
`default_nettype none
// =====================================================================
// Module : ext_obi_addr_router
// Brief  : 1-to-NSLAVE OBI router with in-order responses and error target.
// Rev    : 1.0
// =====================================================================
module ext_obi_addr_router
   import addr_map_rule_pkg::*;
#(
   parameter int                              NSLAVE     = 1,
   parameter int                              ADDR_W     = 32,
   parameter int                              DATA_W     = 32,
   parameter int                              MAX_OUTST  = 4,
   parameter addr_map_rule_t [NSLAVE-1:0]     ADDR_RULES = '0,
   parameter logic [DATA_W-1:0]               ERR_RDATA  = DATA_W'(ext_xbar_pkg::ERR_RDATA)
) (
   input  wire logic              clk_i,
   input  wire logic              rst_i,
   ext_obi_addr_router_if.slave   m_bus,
   ext_obi_addr_router_if.master  s_bus,
   output logic [15:0]            err_cnt_o
);
   localparam int unsigned c_sel_w = $clog2(NSLAVE + 1);
   localparam int unsigned c_cnt_w = $clog2(MAX_OUTST + 1);
   localparam logic [c_sel_w-1:0] c_err_sel = c_sel_w'(NSLAVE);
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_OUTST);

   logic [ADDR_W-1:0]  w_addr;
   logic [31:0]        w_addr_ext;
   logic [c_sel_w-1:0] w_sel;
   logic [NSLAVE-1:0]  w_sel_oh;
   logic [NSLAVE-1:0]  w_cur_oh;
   logic               w_sel_is_err;
   logic               w_cur_is_err;
   logic               w_allow;
   logic               w_slv_gnt;
   logic               w_gnt;
   logic               w_hs;
   logic               w_err_hs;
   logic               w_slv_rvalid;
   logic [DATA_W-1:0]  w_slv_rdata;
   logic               w_rsp_valid;
   logic               w_err_rvalid;
   logic [DATA_W-1:0]  w_err_rdata;
   logic               w_err_flag;

   logic [c_cnt_w-1:0] r_out_cnt;
   logic [c_sel_w-1:0] r_cur_sel;

   assign w_addr     = m_bus.addr;
   assign w_addr_ext = 32'(w_addr);

   // Scan downwards so the lowest matching rule is the last one written.
   always_comb begin
      w_sel = c_err_sel;
      for (int k = NSLAVE - 1; k >= 0; k--) begin
         if ((w_addr_ext >= ADDR_RULES[k].start_addr) &&
             (w_addr_ext <  ADDR_RULES[k].end_addr)) begin
            w_sel = c_sel_w'(k);
         end
      end
   end

   always_comb begin
      w_sel_oh = '0;
      w_cur_oh = '0;
      for (int k = 0; k < NSLAVE; k++) begin
         w_sel_oh[k] = (w_sel == c_sel_w'(k));
         w_cur_oh[k] = (r_cur_sel == c_sel_w'(k));
      end
   end

   assign w_sel_is_err = (w_sel == c_err_sel);
   assign w_cur_is_err = (r_cur_sel == c_err_sel);

   // Responses must come back in order, so a new target waits for an empty pipe.
   assign w_allow = (r_out_cnt == '0) ||
                    ((w_sel == r_cur_sel) && (r_out_cnt < c_cnt_max));

   assign w_slv_gnt = |(s_bus.gnt & w_sel_oh);
   assign w_gnt     = w_allow & (w_sel_is_err ? m_bus.req[0] : w_slv_gnt);
   assign w_hs      = m_bus.req[0] & w_gnt;
   assign w_err_hs  = w_hs & w_sel_is_err;

   assign s_bus.req   = {NSLAVE{m_bus.req[0] & w_allow}} & w_sel_oh;
   assign s_bus.addr  = m_bus.addr;
   assign s_bus.we    = m_bus.we;
   assign s_bus.be    = m_bus.be;
   assign s_bus.wdata = m_bus.wdata;
   assign m_bus.gnt   = w_gnt;

   ext_obi_err_slave #(
      .DATA_W    (DATA_W),
      .ERR_RDATA (ERR_RDATA)
   ) u_err_slave (
      .clk       (clk_i),
      .rst       (rst_i),
      .i_hs      (w_err_hs),
      .o_rvalid  (w_err_rvalid),
      .o_rdata   (w_err_rdata),
      .o_err     (w_err_flag),
      .o_err_cnt (err_cnt_o)
   );

   always_comb begin
      w_slv_rdata = '0;
      for (int k = 0; k < NSLAVE; k++) begin
         if (w_cur_oh[k]) begin
            w_slv_rdata = s_bus.rdata[k*DATA_W +: DATA_W];
         end
      end
   end

   assign w_slv_rvalid = |(s_bus.rvalid & w_cur_oh);

   // With nothing in flight any rvalid is stale (e.g. issued before a reset).
   assign w_rsp_valid = (r_out_cnt != '0) &&
                        (w_cur_is_err ? w_err_rvalid : w_slv_rvalid);

   assign m_bus.rvalid = w_rsp_valid;
   assign m_bus.rdata  = !w_rsp_valid ? '0 :
                         (w_cur_is_err ? w_err_rdata : w_slv_rdata);
   assign m_bus.err    = w_rsp_valid & w_cur_is_err & w_err_flag;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_out_cnt <= '0;
         r_cur_sel <= '0;
      end else begin
         if (w_hs) begin
            r_cur_sel <= w_sel;
         end
         case ({w_hs, w_rsp_valid})
            2'b10:   r_out_cnt <= r_out_cnt + c_cnt_w'(1);
            2'b01:   r_out_cnt <= r_out_cnt - c_cnt_w'(1);
            default: r_out_cnt <= r_out_cnt;
         endcase
      end
   end
endmodule
`default_nettype wire
